// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Holds the controller state encoding and the default datapath widths.
package mult_seq_ctrl_pkg;

    localparam int WIDTH  = 32;
    localparam int CNT_W  = 5;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // BUSY covers every state in which HI/LO hold intermediate values.
    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_FIX);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Request/result bundle between the execute stage and the multiplier.
// The requester drives operands and START; the multiplier returns status and product.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic             SIGNED;
    logic [WIDTH-1:0] OP_A;
    logic [WIDTH-1:0] OP_B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output START, SIGNED, OP_A, OP_B,
        input  BUSY, DONE, HI, LO
    );

    modport slave (
        input  START, SIGNED, OP_A, OP_B,
        output BUSY, DONE, HI, LO
    );
endinterface

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: multiplicand, HI/LO product registers, 33-bit adder,
// one-bit right shifter and 64-bit negator, sequenced by load/step/negate strobes.
module mult_shift_add_dp
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = mult_seq_ctrl_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             negate,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0]   mc_q, mc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_neg;

    // The most-negative operand maps onto itself, which reads correctly as unsigned.
    always_comb begin
        mag_a = (signed_op && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
        mag_b = (signed_op && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
    end

    // The adder carry is shifted straight into the HI MSB, so it needs no separate flop.
    always_comb begin
        sum      = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mc_q : '0)};
        prod_neg = ~{hi_q, lo_q} + (2*WIDTH)'(1);
        mc_d     = mc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (load) begin
            mc_d = mag_a;
            hi_d = '0;
            lo_d = mag_b;
        end else if (step) begin
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        end else if (negate) begin
            {hi_d, lo_d} = prod_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            mc_q <= mc_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative multiplier controller for MUL/MULU: one add/shift step per clock,
// then a sign fix-up, presenting the 64-bit product on HI/LO with a DONE pulse.
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = mult_seq_ctrl_pkg::WIDTH,
    parameter int CNT_W = mult_seq_ctrl_pkg::CNT_W
) (
    input  logic           CLK,
    input  logic           RESET,
    mult_seq_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load, step, negate;
    logic [WIDTH-1:0] hi, lo;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        load    = 1'b0;
        step    = 1'b0;
        negate  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.START) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                    cnt_d   = '0;
                    neg_d   = bus.SIGNED & (bus.OP_A[WIDTH-1] ^ bus.OP_B[WIDTH-1]);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                negate  = neg_q;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Status is derived from the next state so BUSY/DONE come straight from flops.
        busy_d = is_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The datapath must see RESET too so an aborted product is cleared.
    mult_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (CLK),
        .rst       (RESET),
        .load      (load),
        .step      (step),
        .negate    (negate),
        .signed_op (bus.SIGNED),
        .op_a      (bus.OP_A),
        .op_b      (bus.OP_B),
        .hi        (hi),
        .lo        (lo)
    );

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.HI   = hi;
    assign bus.LO   = lo;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: vector table plus scoreboard queue,
// with sequences for ignored START, back-to-back issue and reset abort.
module tb_mult_seq_ctrl;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;
    int          done_cnt;
    int          issued;
    int          aborted;
    logic [63:0] exp_q[$];
    logic [63:0] last_prod;
    vec_t        vecs[10];

    mult_seq_ctrl_if #(.WIDTH(32)) bus();

    mult_seq_ctrl #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'h0, a};
        xb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return xa * xb;
    endfunction

    // Scoreboard: every DONE pops one expected product.
    always @(negedge clk) begin
        if (!rst && bus.DONE) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=DONE required=no_DONE");
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("product", {bus.HI, bus.LO}, e);
            end
        end
    end

    // Called at a negedge; START is sampled at the following posedge.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] e);
        bus.START  = 1'b1;
        bus.SIGNED = s;
        bus.OP_A   = a;
        bus.OP_B   = b;
        @(posedge clk);
        exp_q.push_back(e);
        issued++;
        last_prod = e;
        #1;
        bus.START = 1'b0;
        bus.OP_A  = $urandom;
        bus.OP_B  = $urandom;
        bus.SIGNED = $urandom_range(0, 1) != 0;
    endtask

    // BUSY for cycles 1..33 after the START edge, DONE only in cycle 34.
    task automatic wait_done(input int inj);
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk);
            if (n < 34) begin
                if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
                    chk($sformatf("busy_cyc%0d", n), {62'b0, bus.BUSY, bus.DONE}, 64'h2);
                end
            end else begin
                chk("done_cyc34", {62'b0, bus.BUSY, bus.DONE}, 64'h1);
            end
            if (inj != 0 && n == inj) begin
                bus.START  = 1'b1;
                bus.SIGNED = 1'b0;
                bus.OP_A   = 32'd7;
                bus.OP_B   = 32'd9;
            end
            if (inj != 0 && n == inj + 1) bus.START = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        issued   = 0;
        aborted  = 0;
        bus.START  = 1'b0;
        bus.SIGNED = 1'b0;
        bus.OP_A   = '0;
        bus.OP_B   = '0;

        vecs[0] = '{1'b0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{1'b1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[4] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[6] = '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[7] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[9] = '{1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_status", {62'b0, bus.BUSY, bus.DONE}, 64'h0);
        chk("reset_hilo", {bus.HI, bus.LO}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
            wait_done(0);
            repeat (2) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("idle_hold", {bus.HI, bus.LO}, last_prod);
        chk("idle_status", {62'b0, bus.BUSY, bus.DONE}, 64'h0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom;
            b = $urandom;
            s = (i % 2) == 1;
            start_op(s, a, b, model(s, a, b));
            wait_done(0);
            @(negedge clk);
        end

        // START at cycle 10 of RUN must be ignored.
        start_op(1'b0, 32'd3, 32'd5, 64'd15);
        wait_done(10);
        repeat (3) @(negedge clk);

        // Back-to-back: second START issued in the DONE cycle.
        start_op(1'b1, 32'hFFFFFFF9, 32'h00000003, 64'hFFFFFFFF_FFFFFFEB);
        wait_done(0);
        start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        wait_done(0);
        repeat (2) @(negedge clk);

        // Reset in cycle 20 of RUN aborts the operation with no DONE.
        start_op(1'b0, 32'h12345678, 32'h9ABCDEF0, model(1'b0, 32'h12345678, 32'h9ABCDEF0));
        repeat (20) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        aborted++;
        @(negedge clk);
        chk("abort_status", {62'b0, bus.BUSY, bus.DONE}, 64'h0);
        chk("abort_hilo", {bus.HI, bus.LO}, 64'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(issued - aborted));

        start_op(1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000);
        wait_done(0);
        repeat (2) @(negedge clk);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_total", 64'(done_cnt), 64'(issued - aborted));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
